// File: rtl/seg_pkg.sv
// seg_pkg
//   Shared 7-segment definitions for the display blocks.
//   seg_t      : segment vector {g,f,e,d,c,b,a}, active-low (0 = segment lit)
//   SEG_BLANK  : all segments dark
//   SEG_HEX    : active-low glyphs for hex digits 0-9, A, b, C, d, E, F
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg
//   Combinational decode of one hex nibble into its active-low segment glyph.
//   Ports:
//     nibble  in   4   hex digit value
//     seg     out  7   segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg_display_scanner.sv
// seg_display_scanner
//   Snapshots a register value on LD and scans it continuously, one hex digit
//   at a time, onto a common-anode multiplexed 7-segment display.
//   Ports:
//     CLK  in   1        system clock, rising edge
//     CLR  in   1        asynchronous active-high reset
//     D    in   N        value to display, captured only when LD=1
//     LD   in   1        snapshot strobe
//     EN   in   1        display enable (0 = all dark, scan keeps running)
//     LZB  in   1        leading-zero blanking enable
//     SEG  out  7        segments {g,f,e,d,c,b,a}, active-low, registered
//     AN   out  DIGITS   digit anodes, active-low, registered
//     DP   out  1        decimal point, active-low, always off
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int N           = 16,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   CLK,
    input  logic                   CLR,
    input  logic [N-1:0]           D,
    input  logic                   LD,
    input  logic                   EN,
    input  logic                   LZB,
    output logic [6:0]             SEG,
    output logic [(N+3)/4-1:0]     AN,
    output logic                   DP
);

    localparam int DIGITS = (N + 3) / 4;
    localparam int PW     = ($clog2(REFRESH_DIV) > 0) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // Round the digit slots up to a power of two so any index value
    // selects a real (zero-padded) nibble; unused slots read as zero.
    localparam int SLOTS  = 1 << IW;
    localparam int PADW   = 4 * SLOTS;

    logic [N-1:0]        shadow;
    logic [PW-1:0]       prescaler;
    logic [IW-1:0]       index;
    logic                tick;
    logic [PADW-1:0]     padded;
    logic [SLOTS-1:0]    upper_zero;
    logic                seen_nonzero;
    logic [3:0]          nibble;
    seg_t                decoded;
    logic                lit;
    logic [DIGITS-1:0]   an_next;

    assign DP = 1'b1;

    // Snapshot register: the display only ever looks at this copy, so D is
    // free to move between LD strobes.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            shadow <= '0;
        end else if (LD) begin
            shadow <= D;
        end
    end

    assign tick = (prescaler == PW'(REFRESH_DIV - 1));

    // Refresh prescaler and digit index; the index steps once per full
    // prescaler period and wraps after the last digit.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            prescaler <= '0;
            index     <= '0;
        end else if (tick) begin
            prescaler <= '0;
            index     <= (index == IW'(DIGITS - 1)) ? '0 : index + IW'(1);
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign padded = PADW'(shadow);

    // upper_zero[k] is set when nibble k and everything above it are zero,
    // which is exactly the condition for k being a leading zero.
    always_comb begin
        seen_nonzero = 1'b0;
        upper_zero   = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            seen_nonzero  = seen_nonzero | (padded[4*k +: 4] != 4'h0);
            upper_zero[k] = ~seen_nonzero;
        end
    end

    assign nibble = padded[4*index +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (decoded)
    );

    // Digit 0 is exempt from blanking so a zero value still shows "0".
    assign lit = EN && !(LZB && (index != '0) && upper_zero[index]);

    always_comb begin
        an_next = '1;
        for (int k = 0; k < DIGITS; k++) begin
            an_next[k] = !(lit && (index == IW'(k)));
        end
    end

    // Output stage: registering both anodes and segments from the same
    // snapshot of index/shadow keeps them aligned, so a digit never shows a
    // glyph from a different nibble or value.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            SEG <= SEG_BLANK;
            AN  <= '1;
        end else begin
            SEG <= lit ? decoded : SEG_BLANK;
            AN  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner
//   Drives a 16-bit and a 6-bit scanner side by side and compares every cycle
//   against a cycle-count based reference of what the display should show.
module tb_seg_display_scanner;

    localparam int RD   = 4;
    localparam int DG   = 4;
    localparam int DG_S = 2;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [15:0] D;
    logic [5:0]  d_small;
    logic        LD, EN, LZB;
    logic [6:0]  SEG, seg_small;
    logic [3:0]  AN;
    logic [1:0]  an_small;
    logic        DP, dp_small;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int          m_cycles;
    logic [15:0] m_shadow;
    logic [5:0]  m_shadow_s;
    logic [6:0]  exp_seg, exp_seg_s;
    logic [3:0]  exp_an, exp_an_s;

    logic [3:0]  dir_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0]  dir_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};

    seg_display_scanner #(.N(16), .REFRESH_DIV(RD)) dut (
        .CLK (CLK), .CLR (CLR), .D (D), .LD (LD), .EN (EN), .LZB (LZB),
        .SEG (SEG), .AN (AN), .DP (DP)
    );

    seg_display_scanner #(.N(6), .REFRESH_DIV(RD)) dut_small (
        .CLK (CLK), .CLR (CLR), .D (d_small), .LD (LD), .EN (EN), .LZB (LZB),
        .SEG (seg_small), .AN (an_small), .DP (dp_small)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // What a display of ndig digits should show after cyc refresh clocks.
    function automatic void refOut(input int cyc, input logic [15:0] sh, input int ndig,
                                   input logic en, input logic lzb,
                                   output logic [6:0] seg, output logic [3:0] an);
        int idx;
        logic [15:0] upper;
        idx   = (cyc / RD) % ndig;
        upper = sh >> (4 * idx);
        seg   = 7'h7F;
        an    = 4'hF;
        if (en && !(lzb && idx > 0 && upper == 16'h0)) begin
            seg     = hex_tab[upper[3:0]];
            an[idx] = 1'b0;
        end
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, "_seg"},   SEG,       exp_seg);
        checkOutput({tag, "_an"},    AN,        exp_an);
        checkOutput({tag, "_dp"},    DP,        1);
        checkOutput({tag, "_sseg"},  seg_small, exp_seg_s);
        checkOutput({tag, "_san"},   an_small,  exp_an_s[1:0]);
    endtask

    // One clock: outputs after the edge reflect the state before it.
    task automatic applyStimulus(input logic [15:0] d, input logic [5:0] ds,
                                 input logic ld, input logic en, input logic lzb,
                                 input string tag);
        D = d; d_small = ds; LD = ld; EN = en; LZB = lzb;
        @(posedge CLK);
        refOut(m_cycles, m_shadow, DG, EN, LZB, exp_seg, exp_an);
        refOut(m_cycles, {10'h0, m_shadow_s}, DG_S, EN, LZB, exp_seg_s, exp_an_s);
        if (LD) begin
            m_shadow   = D;
            m_shadow_s = d_small;
        end
        m_cycles++;
        @(negedge CLK);
        checkAll(tag);
    endtask

    task automatic doReset();
        LD = 1'b0;
        #2 CLR = 1'b1;
        #1;
        exp_seg = 7'h7F; exp_an = 4'hF; exp_seg_s = 7'h7F; exp_an_s = 4'hF;
        checkAll("rst_async");
        repeat (3) begin
            @(negedge CLK);
            checkAll("rst_hold");
        end
        CLR = 1'b0;
        m_cycles   = 0;
        m_shadow   = 16'h0;
        m_shadow_s = 6'h0;
    endtask

    initial begin
        logic [15:0] rd;
        CLR = 1'b1; D = '0; d_small = '0; LD = 0; EN = 1; LZB = 0;
        m_cycles = 0; m_shadow = '0; m_shadow_s = '0;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;

        // Scan a few digits, then reset mid-scan.
        for (int i = 0; i < 6; i++) applyStimulus(16'h5A5A, 6'h15, i == 0, 1, 0, "prerun");
        doReset();
        applyStimulus(16'h0, 6'h0, 0, 1, 0, "first_lit");
        checkOutput("first_an_E", AN, 4'hE);

        // Full scan of 0x12AF.
        doReset();
        applyStimulus(16'h12AF, 6'h2A, 1, 1, 0, "load12af");
        for (int k = 2; k < 18; k++) begin
            applyStimulus(16'h12AF, 6'h2A, 0, 1, 0, "scan12af");
            if ((k - 2) % 4 == 0) begin
                checkOutput("dir_an",  AN,  dir_an[(k-2)/4]);
                checkOutput("dir_seg", SEG, dir_seg[(k-2)/4]);
            end
        end

        // Leading-zero blanking, then an all-zero value.
        applyStimulus(16'h0030, 6'h03, 1, 1, 1, "lzb_load");
        for (int k = 0; k < 16; k++) applyStimulus(16'hFFFF, 6'h3F, 0, 1, 1, "lzb_0030");
        applyStimulus(16'h0000, 6'h00, 1, 1, 1, "lzb_zero_load");
        for (int k = 0; k < 16; k++) applyStimulus(16'hFFFF, 6'h3F, 0, 1, 1, "lzb_zero");

        // LD exactly on the index-advance cycle.
        applyStimulus(16'h1111, 6'h11, 1, 1, 0, "ld1111");
        for (int k = 0; k < RD && (m_cycles % RD) != 3; k++)
            applyStimulus(16'h1111, 6'h11, 0, 1, 0, "align");
        applyStimulus(16'h2222, 6'h22, 1, 1, 0, "ld_at_wrap");
        applyStimulus(16'h3333, 6'h33, 0, 1, 0, "after_wrap");
        checkOutput("wrap_seg_2", SEG, 7'h24);
        for (int k = 0; k < 8; k++) applyStimulus(16'h3333 + 16'(k), 6'h33, 0, 1, 0, "d_ignored");

        // Display disabled while scanning continues.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(16'h3333, 6'h33, 0, 0, 0, "en_off");
            checkOutput("en_off_an", AN, 4'hF);
        end
        for (int k = 0; k < 8; k++) applyStimulus(16'h3333, 6'h33, 0, 1, 0, "en_on");

        // Small instance with 0x3F.
        applyStimulus(16'h0000, 6'h3F, 1, 1, 0, "small_load");
        for (int k = 0; k < 8; k++) applyStimulus(16'h0000, 6'h00, 0, 1, 0, "small_3f");

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            rd = 16'($urandom);
            for (int n = 0; n < 4; n++)
                if ($urandom_range(1, 0) == 0) rd[4*n +: 4] = 4'h0;
            applyStimulus(rd, 6'($urandom), $urandom_range(3, 0) == 0,
                          $urandom_range(7, 0) != 0, 1'($urandom), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
